// File: rtl/cu_fsm_pkg.sv
// Shared types and constants for the OTTER multicycle control unit.
// Optional illegal-opcode trap is enabled with CU_FSM_ILLEGAL_TRAP_EN.
package cu_fsm_pkg;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_FETCH,
      ST_EXEC,
      ST_WRITEBACK,
      ST_INTR
   } state_t;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [2:0] FUNCT3_PRIV = 3'b000;

   localparam int WAIT_W = 4;

endpackage

// File: rtl/cu_wait_cnt.sv
// Wait-state up-counter shared by the fetch and load waits; done flags
// that the count has reached the current limit.
module cu_wait_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= count + 1'b1;
   end

   assign done = (count == limit);

endmodule

// File: rtl/cu_fsm_irq.sv
// Multicycle OTTER control FSM with memory wait states, CSR/mret and interrupt entry.
// Define CU_FSM_ILLEGAL_TRAP_EN to trap unknown opcodes through ST_INTR.
module cu_fsm_irq
   import cu_fsm_pkg::*;
#(
   parameter int unsigned FETCH_WAIT = 0,
   parameter int unsigned LOAD_WAIT  = 0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [6:0] ir6_0,
   input  logic [2:0] ir14_12,
   input  logic       intr,
   input  logic       mie,
   output logic       PCWrite,
   output logic       regWrite,
   output logic       memWE2,
   output logic       memRDEN1,
   output logic       memRDEN2,
   output logic       reset,
   output logic       csr_WE,
   output logic       int_taken,
   output logic       mret_exec
`ifdef CU_FSM_ILLEGAL_TRAP_EN
   ,
   output logic       illegal_op
`endif
);

   localparam logic [WAIT_W-1:0] FETCH_LIMIT = WAIT_W'(FETCH_WAIT);
   localparam logic [WAIT_W-1:0] LOAD_LIMIT  = WAIT_W'(LOAD_WAIT);

   state_t            state;
   state_t            next_state;
   logic              cnt_clr;
   logic              cnt_en;
   logic              cnt_done;
   logic              instr_done;
   logic [WAIT_W-1:0] cnt_limit;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state <= ST_INIT;
      else
         state <= next_state;
   end

   // One counter serves both waits; the active state picks the limit.
   assign cnt_limit = (state == ST_FETCH) ? FETCH_LIMIT : LOAD_LIMIT;

   cu_wait_cnt #(.W(WAIT_W)) u_wait_cnt (
      .clk   (CLK),
      .rst   (RST),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .limit (cnt_limit),
      .done  (cnt_done)
   );

   always_comb begin
      next_state = ST_INIT;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      instr_done = 1'b0;
      PCWrite    = 1'b0;
      regWrite   = 1'b0;
      memWE2     = 1'b0;
      memRDEN1   = 1'b0;
      memRDEN2   = 1'b0;
      reset      = 1'b0;
      csr_WE     = 1'b0;
      int_taken  = 1'b0;
      mret_exec  = 1'b0;
`ifdef CU_FSM_ILLEGAL_TRAP_EN
      illegal_op = 1'b0;
`endif

      case (state)
         ST_INIT: begin
            reset      = 1'b1;
            cnt_clr    = 1'b1;
            next_state = ST_FETCH;
         end

         ST_FETCH: begin
            memRDEN1 = 1'b1;
            if (cnt_done) begin
               cnt_clr    = 1'b1;
               next_state = ST_EXEC;
            end else begin
               cnt_en     = 1'b1;
               next_state = ST_FETCH;
            end
         end

         ST_EXEC: begin
            instr_done = 1'b1;
            case (ir6_0)
               OP_RTYPE, OP_ITYPE, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL: begin
                  PCWrite  = 1'b1;
                  regWrite = 1'b1;
               end
               OP_STORE: begin
                  PCWrite = 1'b1;
                  memWE2  = 1'b1;
               end
               OP_BRANCH: begin
                  PCWrite = 1'b1;
               end
               OP_LOAD: begin
                  instr_done = 1'b0;
                  memRDEN2   = 1'b1;
                  if (cnt_done) begin
                     cnt_clr    = 1'b1;
                     next_state = ST_WRITEBACK;
                  end else begin
                     cnt_en     = 1'b1;
                     next_state = ST_EXEC;
                  end
               end
               OP_SYSTEM: begin
                  PCWrite = 1'b1;
                  if (ir14_12 == FUNCT3_PRIV) begin
                     mret_exec = 1'b1;
                  end else begin
                     regWrite = 1'b1;
                     csr_WE   = 1'b1;
                  end
               end
               default: begin
`ifdef CU_FSM_ILLEGAL_TRAP_EN
                  illegal_op = 1'b1;
                  instr_done = 1'b0;
                  next_state = ST_INTR;
`else
                  PCWrite = 1'b1;
`endif
               end
            endcase
         end

         ST_WRITEBACK: begin
            PCWrite    = 1'b1;
            regWrite   = 1'b1;
            instr_done = 1'b1;
         end

         ST_INTR: begin
            int_taken  = 1'b1;
            PCWrite    = 1'b1;
            next_state = ST_FETCH;
         end

         default: begin
            next_state = ST_INIT;
         end
      endcase

      // Interrupts are only taken at an instruction boundary.
      if (instr_done) begin
         cnt_clr    = 1'b1;
         next_state = (intr && mie) ? ST_INTR : ST_FETCH;
      end
   end

endmodule

// File: tb/tb_cu_fsm_irq.sv
// Self-checking bench for cu_fsm_irq: directed and random instructions against
// a per-instruction cycle-sequence model; honours CU_FSM_ILLEGAL_TRAP_EN.
module tb_cu_fsm_irq;

   localparam int FW = 2;
   localparam int LW = 1;

   localparam logic [9:0] V_ILL  = 10'h200;
   localparam logic [9:0] V_PC   = 10'h100;
   localparam logic [9:0] V_RW   = 10'h080;
   localparam logic [9:0] V_WE2  = 10'h040;
   localparam logic [9:0] V_RD1  = 10'h020;
   localparam logic [9:0] V_RD2  = 10'h010;
   localparam logic [9:0] V_RST  = 10'h008;
   localparam logic [9:0] V_CSR  = 10'h004;
   localparam logic [9:0] V_INT  = 10'h002;
   localparam logic [9:0] V_MRET = 10'h001;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [6:0] ir6_0 = 7'b0;
   logic [2:0] ir14_12 = 3'b0;
   logic       intr = 1'b0;
   logic       mie = 1'b0;
   logic       PCWrite, regWrite, memWE2, memRDEN1, memRDEN2;
   logic       reset, csr_WE, int_taken, mret_exec;
   logic       ill_obs;

   int compared = 0;
   int mismatched = 0;
   logic [9:0] expQ[$];

   logic [6:0] knownOps[10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                7'b0010111, 7'b1110011};

   cu_fsm_irq #(.FETCH_WAIT(FW), .LOAD_WAIT(LW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .ir6_0     (ir6_0),
      .ir14_12   (ir14_12),
      .intr      (intr),
      .mie       (mie),
      .PCWrite   (PCWrite),
      .regWrite  (regWrite),
      .memWE2    (memWE2),
      .memRDEN1  (memRDEN1),
      .memRDEN2  (memRDEN2),
      .reset     (reset),
      .csr_WE    (csr_WE),
      .int_taken (int_taken),
      .mret_exec (mret_exec)
`ifdef CU_FSM_ILLEGAL_TRAP_EN
      ,
      .illegal_op (ill_obs)
`endif
   );

`ifndef CU_FSM_ILLEGAL_TRAP_EN
   assign ill_obs = 1'b0;
`endif

   always #5 CLK = ~CLK;

   function automatic logic [9:0] observed();
      return {ill_obs, PCWrite, regWrite, memWE2, memRDEN1, memRDEN2,
              reset, csr_WE, int_taken, mret_exec};
   endfunction

   function automatic bit isKnown(input logic [6:0] op);
      foreach (knownOps[k])
         if (knownOps[k] == op) return 1'b1;
      return 1'b0;
   endfunction

   task automatic checkOutput(input string tag, input logic [9:0] exp);
      logic [9:0] obs;
      obs = observed();
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                input logic irq, input logic ie);
      ir6_0   = op;
      ir14_12 = f3;
      intr    = irq;
      mie     = ie;
   endtask

   // Cycle-by-cycle output sequence of one instruction from its class.
   task automatic buildExpected(input logic [6:0] op, input logic [2:0] f3,
                                input logic irq, input logic ie);
      bit trapped;
      trapped = 1'b0;
      expQ.delete();
      repeat (FW + 1) expQ.push_back(V_RD1);
      if (op == 7'b0000011) begin
         repeat (LW + 1) expQ.push_back(V_RD2);
         expQ.push_back(V_PC | V_RW);
      end else if (op == 7'b1110011) begin
         expQ.push_back((f3 == 3'b000) ? (V_PC | V_MRET) : (V_PC | V_RW | V_CSR));
      end else if (op == 7'b0100011) begin
         expQ.push_back(V_PC | V_WE2);
      end else if (op == 7'b1100011) begin
         expQ.push_back(V_PC);
      end else if (isKnown(op)) begin
         expQ.push_back(V_PC | V_RW);
      end else begin
`ifdef CU_FSM_ILLEGAL_TRAP_EN
         expQ.push_back(V_ILL);
         expQ.push_back(V_PC | V_INT);
         trapped = 1'b1;
`else
         expQ.push_back(V_PC);
`endif
      end
      if (!trapped && irq && ie)
         expQ.push_back(V_PC | V_INT);
   endtask

   // Runs one instruction; abortAt>=0 stops after that many checked cycles.
   task automatic runInstr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic irq, input logic ie, input int abortAt);
      buildExpected(op, f3, irq, ie);
      for (int i = 0; i < expQ.size(); i++) begin
         if (abortAt >= 0 && i == abortAt) break;
         @(posedge CLK);
         #2;
         if (i == 0) applyStimulus(op, f3, irq, ie);
         #1;
         checkOutput($sformatf("%s.c%0d", name, i), expQ[i]);
      end
   endtask

   task automatic resetPulse(input string name);
      RST = 1'b1;
      #1;
      checkOutput({name, ".asserted"}, V_RST);
      #2;
      RST = 1'b0;
      #1;
      checkOutput({name, ".released"}, V_RST);
   endtask

   initial begin
      logic [6:0] op;
      logic [2:0] f3;
      int idx;

      #6;
      resetPulse("por");

      runInstr("addi",      7'b0010011, 3'b000, 1'b0, 1'b0, -1);
      runInstr("lw",        7'b0000011, 3'b010, 1'b0, 1'b0, -1);
      runInstr("csrrw",     7'b1110011, 3'b001, 1'b0, 1'b0, -1);
      runInstr("mret",      7'b1110011, 3'b000, 1'b0, 1'b0, -1);
      runInstr("sw_irq",    7'b0100011, 3'b010, 1'b1, 1'b1, -1);
      runInstr("sw_nomie",  7'b0100011, 3'b010, 1'b1, 1'b0, -1);
      runInstr("lw_irq",    7'b0000011, 3'b010, 1'b1, 1'b1, -1);
      runInstr("mret_irq",  7'b1110011, 3'b000, 1'b1, 1'b1, -1);
      runInstr("unknown",   7'b1111111, 3'b000, 1'b0, 1'b0, -1);
      runInstr("beq",       7'b1100011, 3'b000, 1'b0, 1'b1, -1);

      runInstr("lw_abort",  7'b0000011, 3'b010, 1'b0, 1'b0, FW + 2);
      resetPulse("rst_midload");
      runInstr("jal",       7'b1101111, 3'b000, 1'b0, 1'b0, -1);
      runInstr("fe_abort",  7'b0110011, 3'b000, 1'b0, 1'b0, 2);
      resetPulse("rst_midfetch");
      runInstr("int_abort", 7'b0100011, 3'b000, 1'b1, 1'b1, FW + 3);
      resetPulse("rst_midintr");

      for (int n = 0; n < 40; n++) begin
         idx = $urandom_range(0, 10);
         if (idx == 10) begin
            op = 7'($urandom);
            while (isKnown(op)) op = 7'($urandom);
         end else begin
            op = knownOps[idx];
         end
         f3 = 3'($urandom);
         runInstr($sformatf("rnd%0d", n), op, f3, 1'($urandom), 1'($urandom), -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
